// File: rtl/dcache_ctrl.sv
// Direct-mapped write-back, write-allocate data cache for the MEM stage.
// Ports: clk_i/rst_i (async active-low), cpu_* request/response, mem_* line bus.
module dcache_ctrl #(
    parameter int SETS      = 16,
    parameter int LINE_BITS = 256,
    parameter int TAG_W     = 23
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [31:0]          cpu_addr_i,
    input  logic [31:0]          cpu_data_i,
    input  logic                 cpu_MemRead_i,
    input  logic                 cpu_MemWrite_i,
    output logic [31:0]          cpu_data_o,
    output logic                 cpu_stall_o,
    output logic                 mem_enable_o,
    output logic                 mem_write_o,
    output logic [31:0]          mem_addr_o,
    output logic [LINE_BITS-1:0] mem_data_o,
    input  logic [LINE_BITS-1:0] mem_data_i,
    input  logic                 mem_ack_i
);

    localparam int IDX_W = $clog2(SETS);
    localparam int OFF_W = $clog2(LINE_BITS / 8);
    localparam int BIT_W = $clog2(LINE_BITS);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WRITEBACK = 2'd1,
        FETCH     = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [SETS-1:0]      valid_q;
    logic [SETS-1:0]      dirty_q;
    logic [TAG_W-1:0]     tag_q  [SETS];
    logic [LINE_BITS-1:0] data_q [SETS];

    logic [IDX_W-1:0]   idx;
    logic [TAG_W-1:0]   tag;
    logic [OFF_W-3:0]   word_off;
    logic [BIT_W-1:0]   bit_base;
    logic               req;
    logic               hit;
    logic               store_hit;
    logic               fill;
    logic               unused_addr;

    assign idx       = cpu_addr_i[OFF_W +: IDX_W];
    assign tag       = cpu_addr_i[31 -: TAG_W];
    assign word_off  = cpu_addr_i[OFF_W-1:2];
    assign bit_base  = {word_off, 5'b0};
    assign req       = cpu_MemRead_i | cpu_MemWrite_i;
    assign hit       = valid_q[idx] & (tag_q[idx] == tag);
    // Stores (including read+write) only update the array from IDLE.
    assign store_hit = (state_q == IDLE) & cpu_MemWrite_i & hit;
    assign fill      = (state_q == FETCH) & mem_ack_i;
    assign unused_addr = ^cpu_addr_i[1:0];

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= IDLE;
            valid_q <= '0;
            dirty_q <= '0;
        end else begin
            state_q <= state_d;
            if (fill) begin
                valid_q[idx] <= 1'b1;
                dirty_q[idx] <= 1'b0;
            end else if (store_hit) begin
                dirty_q[idx] <= 1'b1;
            end
        end
    end

    // Tag and data carry no reset; valid gates every use.
    always_ff @(posedge clk_i) begin
        if (fill) begin
            tag_q[idx]  <= tag;
            data_q[idx] <= mem_data_i;
        end else if (store_hit) begin
            data_q[idx][bit_base +: 32] <= cpu_data_i;
        end
    end

    always_comb begin
        state_d      = state_q;
        cpu_stall_o  = 1'b0;
        cpu_data_o   = '0;
        mem_enable_o = 1'b0;
        mem_write_o  = 1'b0;
        mem_addr_o   = '0;
        mem_data_o   = '0;
        unique case (state_q)
            IDLE: begin
                if (req) begin
                    if (hit) begin
                        if (!cpu_MemWrite_i) begin
                            cpu_data_o = data_q[idx][bit_base +: 32];
                        end
                    end else begin
                        cpu_stall_o = 1'b1;
                        state_d = (valid_q[idx] & dirty_q[idx]) ? WRITEBACK : FETCH;
                    end
                end
            end
            WRITEBACK: begin
                cpu_stall_o  = 1'b1;
                mem_enable_o = 1'b1;
                mem_write_o  = 1'b1;
                mem_addr_o   = {tag_q[idx], idx, {OFF_W{1'b0}}};
                mem_data_o   = data_q[idx];
                if (mem_ack_i) state_d = FETCH;
            end
            FETCH: begin
                cpu_stall_o  = 1'b1;
                mem_enable_o = 1'b1;
                mem_addr_o   = {tag, idx, {OFF_W{1'b0}}};
                if (mem_ack_i) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        // An abandoned miss must not hold the pipeline while in reset.
        if (!rst_i) cpu_stall_o = 1'b0;
    end

endmodule

// File: tb/tb_dcache_ctrl.sv
// Directed bench for dcache_ctrl: fills, hits, write-back, store merge,
// fast acks, spurious acks and reset abandoning a miss.
module tb_dcache_ctrl;

    logic         clk_i = 1'b0;
    logic         rst_i = 1'b1;
    logic [31:0]  cpu_addr_i = '0;
    logic [31:0]  cpu_data_i = '0;
    logic         cpu_MemRead_i = 1'b0;
    logic         cpu_MemWrite_i = 1'b0;
    logic [31:0]  cpu_data_o;
    logic         cpu_stall_o;
    logic         mem_enable_o;
    logic         mem_write_o;
    logic [31:0]  mem_addr_o;
    logic [255:0] mem_data_o;
    logic [255:0] mem_data_i = '0;
    logic         mem_ack_i = 1'b0;

    int total = 0;
    int bad = 0;

    dcache_ctrl dut (
        .clk_i(clk_i),
        .rst_i(rst_i),
        .cpu_addr_i(cpu_addr_i),
        .cpu_data_i(cpu_data_i),
        .cpu_MemRead_i(cpu_MemRead_i),
        .cpu_MemWrite_i(cpu_MemWrite_i),
        .cpu_data_o(cpu_data_o),
        .cpu_stall_o(cpu_stall_o),
        .mem_enable_o(mem_enable_o),
        .mem_write_o(mem_write_o),
        .mem_addr_o(mem_addr_o),
        .mem_data_o(mem_data_o),
        .mem_data_i(mem_data_i),
        .mem_ack_i(mem_ack_i)
    );

    always #5 clk_i = ~clk_i;

    function automatic logic [255:0] mk_line(input logic [31:0] a);
        logic [255:0] l;
        for (int i = 0; i < 8; i++) begin
            l[i*32 +: 32] = {8'hA5, a[23:5], 5'b0} + 32'(i);
        end
        return l;
    endfunction

    task automatic chk(input string tag, input logic [255:0] obs,
                       input logic [255:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step;
        @(posedge clk_i);
        #1;
    endtask

    task automatic load(input logic [31:0] a);
        cpu_addr_i = a;
        cpu_MemRead_i = 1'b1;
        cpu_MemWrite_i = 1'b0;
    endtask

    task automatic store(input logic [31:0] a, input logic [31:0] d);
        cpu_addr_i = a;
        cpu_data_i = d;
        cpu_MemRead_i = 1'b0;
        cpu_MemWrite_i = 1'b1;
    endtask

    task automatic idle_cpu;
        cpu_MemRead_i = 1'b0;
        cpu_MemWrite_i = 1'b0;
    endtask

    logic [255:0] l40;

    initial begin
        l40 = mk_line(32'h40);
        #1 rst_i = 1'b0;
        #2;
        chk("rst_stall", 256'(cpu_stall_o), 256'(0));
        chk("rst_en", 256'(mem_enable_o), 256'(0));
        chk("rst_wr", 256'(mem_write_o), 256'(0));
        chk("rst_addr", 256'(mem_addr_o), 256'(0));
        chk("rst_mdata", mem_data_o, 256'(0));
        chk("rst_cdata", 256'(cpu_data_o), 256'(0));
        step;
        step;
        rst_i = 1'b1;

        // clean load miss at 0x40, ack on the third FETCH cycle (A=3)
        load(32'h40);
        #1 chk("ld40_miss_stall", 256'(cpu_stall_o), 256'(1));
        chk("ld40_miss_en", 256'(mem_enable_o), 256'(0));
        step;
        chk("ld40_f_stall", 256'(cpu_stall_o), 256'(1));
        chk("ld40_f_en", 256'(mem_enable_o), 256'(1));
        chk("ld40_f_wr", 256'(mem_write_o), 256'(0));
        chk("ld40_f_addr", 256'(mem_addr_o), 256'(32'h40));
        mem_data_i = l40;
        step;
        chk("ld40_f2_stall", 256'(cpu_stall_o), 256'(1));
        step;
        mem_ack_i = 1'b1;
        #1 chk("ld40_f3_stall", 256'(cpu_stall_o), 256'(1));
        step;
        mem_ack_i = 1'b0;
        #1 chk("ld40_hit_stall", 256'(cpu_stall_o), 256'(0));
        chk("ld40_hit_data", 256'(cpu_data_o), 256'(32'hA5000040));
        chk("ld40_en_drop", 256'(mem_enable_o), 256'(0));
        chk("ld40_valid2", 256'(dut.valid_q[2]), 256'(1));

        // store hit then load hit
        store(32'h44, 32'hDEADBEEF);
        #1 chk("st44_stall", 256'(cpu_stall_o), 256'(0));
        chk("st44_cdata", 256'(cpu_data_o), 256'(0));
        step;
        load(32'h44);
        #1 chk("ld44_data", 256'(cpu_data_o), 256'(32'hDEADBEEF));
        chk("ld44_stall", 256'(cpu_stall_o), 256'(0));
        chk("dirty2", 256'(dut.dirty_q[2]), 256'(1));
        step;

        // dirty conflict miss at 0x240 (set 2, tag 1), A=1 both phases
        load(32'h240);
        #1 chk("ld240_stall", 256'(cpu_stall_o), 256'(1));
        step;
        chk("wb_en", 256'(mem_enable_o), 256'(1));
        chk("wb_wr", 256'(mem_write_o), 256'(1));
        chk("wb_addr", 256'(mem_addr_o), 256'(32'h40));
        chk("wb_word1", 256'(mem_data_o[63:32]), 256'(32'hDEADBEEF));
        chk("wb_word0", 256'(mem_data_o[31:0]), 256'(32'hA5000040));
        mem_ack_i = 1'b1;
        step;
        mem_ack_i = 1'b0;
        mem_data_i = mk_line(32'h240);
        #1 chk("f240_en", 256'(mem_enable_o), 256'(1));
        chk("f240_wr", 256'(mem_write_o), 256'(0));
        chk("f240_addr", 256'(mem_addr_o), 256'(32'h240));
        chk("f240_stall", 256'(cpu_stall_o), 256'(1));
        mem_ack_i = 1'b1;
        step;
        mem_ack_i = 1'b0;
        #1 chk("ld240_stall0", 256'(cpu_stall_o), 256'(0));
        chk("ld240_data", 256'(cpu_data_o), 256'(32'hA5000240));
        chk("dirty2_clr", 256'(dut.dirty_q[2]), 256'(0));
        step;

        // store miss to clean set 4, A=2, merged after the fill
        store(32'h80, 32'h12345678);
        #1 chk("st80_stall", 256'(cpu_stall_o), 256'(1));
        step;
        chk("st80_f_wr", 256'(mem_write_o), 256'(0));
        chk("st80_f_addr", 256'(mem_addr_o), 256'(32'h80));
        mem_data_i = mk_line(32'h80);
        step;
        mem_ack_i = 1'b1;
        step;
        mem_ack_i = 1'b0;
        #1 chk("st80_replay_stall", 256'(cpu_stall_o), 256'(0));
        step;
        chk("dirty4", 256'(dut.dirty_q[4]), 256'(1));
        load(32'h80);
        #1 chk("ld80_data", 256'(cpu_data_o), 256'(32'h12345678));
        step;
        load(32'h84);
        #1 chk("ld84_data", 256'(cpu_data_o), 256'(32'hA5000081));
        step;

        // A=1 clean miss at 0xC0: exactly two stall cycles
        load(32'hC0);
        mem_data_i = mk_line(32'hC0);
        #1 chk("ldC0_s1", 256'(cpu_stall_o), 256'(1));
        step;
        mem_ack_i = 1'b1;
        #1 chk("ldC0_s2", 256'(cpu_stall_o), 256'(1));
        step;
        mem_ack_i = 1'b0;
        #1 chk("ldC0_s3", 256'(cpu_stall_o), 256'(0));
        chk("ldC0_data", 256'(cpu_data_o), 256'(32'hA50000C0));

        // spurious ack while idle
        idle_cpu();
        mem_ack_i = 1'b1;
        #1 chk("idle_cdata", 256'(cpu_data_o), 256'(0));
        step;
        mem_ack_i = 1'b0;
        #1 chk("spur_en", 256'(mem_enable_o), 256'(0));
        chk("spur_stall", 256'(cpu_stall_o), 256'(0));
        load(32'hC0);
        #1 chk("spur_hit", 256'(cpu_stall_o), 256'(0));
        step;

        // reset during FETCH abandons the miss
        load(32'h100);
        step;
        chk("f100_en", 256'(mem_enable_o), 256'(1));
        rst_i = 1'b0;
        #1 chk("rstmid_en", 256'(mem_enable_o), 256'(0));
        chk("rstmid_stall", 256'(cpu_stall_o), 256'(0));
        chk("rstmid_valid", 256'(dut.valid_q), 256'(0));
        step;
        rst_i = 1'b1;
        #1 chk("re_miss", 256'(cpu_stall_o), 256'(1));
        step;
        chk("re_f_addr", 256'(mem_addr_o), 256'(32'h100));
        mem_data_i = mk_line(32'h100);
        mem_ack_i = 1'b1;
        step;
        mem_ack_i = 1'b0;

        // read and write together behaves as a store
        cpu_data_i = 32'hCAFEF00D;
        cpu_MemWrite_i = 1'b1;
        #1 chk("rw_stall", 256'(cpu_stall_o), 256'(0));
        chk("rw_cdata", 256'(cpu_data_o), 256'(0));
        step;
        load(32'h100);
        #1 chk("rw_ld", 256'(cpu_data_o), 256'(32'hCAFEF00D));
        step;
        idle_cpu();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
